bp_addr_gen_bank: RTL and testbench
===================================

BP_ADDR_GEN_BANK -- requirements
Module: bp_addr_gen_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, width of every address output.
REQ-002 Parameter NUM_CELL, default 8, cells per timestep (aioht/dstate/dwu row length).
REQ-003 Parameter NUM_INPUT, default 53, input-vector length for the weight-address generator.
REQ-004 Parameter TIMESTEP, default 7, number of timesteps, walked backward.
REQ-005 Parameter DELTA_TIME, default 12, cycles spent per cell in delta and dstate sequencing.
REQ-006 Parameter DSTATE_DELAY, default 12, enabled-cycle lag of dstate write address behind read address.
REQ-007 Parameter DWU_DELAY, default 2, idle cycles inserted after each weight row.
REQ-008 clk  input  1  sole clock; all state updates on rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 en_delta  input  1  advances the aioht/dgates sequencer.
REQ-011 en_dstate  input  1  advances the dstate read/write sequencer.
REQ-012 en_dwu  input  1  advances the d/w matrix sequencer.
REQ-013 o_addr_aioht  output  ADDR_WIDTH  read address of a/i/o/h/t buffers.
REQ-014 o_addr_dgates  output  ADDR_WIDTH  write address of delta-gate buffers.
REQ-015 o_addr_rd / o_addr_wr  output  ADDR_WIDTH each  dstate read / write addresses.
REQ-016 o_addr_d / o_addr_w  output  ADDR_WIDTH each  delta-gate read address / weight read address.

Function
REQ-017 Each of the three sequencers SHALL be independent; an enable low holds that sequencer's state and outputs unchanged.
REQ-018 All outputs SHALL derive from registered state only; no combinational path from any enable to any output.
REQ-019 Aioht: counters cyc (0..DELTA_TIME-1), cell (0..NUM_CELL-1), t (TIMESTEP-1 down to 0); per enabled cycle cyc++; at cyc=DELTA_TIME-1 cyc->0 and cell++; at cell wrap cell->0 and t--, t wrapping 0->TIMESTEP-1.
REQ-020 o_addr_aioht SHALL equal t*NUM_CELL+cell.
REQ-021 o_addr_dgates SHALL load the current o_addr_aioht on each enabled cycle with cyc=DELTA_TIME-1, i.e. lag aioht by exactly one cell window.
REQ-022 Dstate: counters cyc and cell as in REQ-019 (no timestep); o_addr_rd=cell, wrapping NUM_CELL-1 -> 0.
REQ-023 o_addr_wr SHALL equal the o_addr_rd value DSTATE_DELAY enabled cycles earlier, and 0 during the first DSTATE_DELAY enabled cycles after reset.
REQ-024 Dwu: states ACTIVE and GAP; counters k (0..NUM_CELL-1), j (0..NUM_INPUT-1), t (TIMESTEP-1 down to 0), gap count g.
REQ-025 ACTIVE: per enabled cycle k++; on enabled cycle with k=NUM_CELL-1 go GAP with g=0 (k held); if DWU_DELAY=0 instead go directly to the row-advance action.
REQ-026 GAP: per enabled cycle g++; on enabled cycle with g=DWU_DELAY-1 perform row advance: k->0, j++, at j=NUM_INPUT-1 j->0 and t-- (wrap 0->TIMESTEP-1), return ACTIVE.
REQ-027 o_addr_d SHALL equal t*NUM_CELL+k; o_addr_w SHALL equal k*NUM_INPUT+j; both held through GAP.
REQ-028 Address arithmetic SHALL be unsigned, truncated to ADDR_WIDTH bits.

Reset
REQ-029 With rst high at a clock edge, regardless of enables: all cyc/cell/k/j/g counters -> 0, t -> TIMESTEP-1, dwu state -> ACTIVE, dstate delay counter cleared.
REQ-030 Reset values: o_addr_aioht=o_addr_dgates=(TIMESTEP-1)*NUM_CELL, o_addr_rd=o_addr_wr=0, o_addr_d=(TIMESTEP-1)*NUM_CELL, o_addr_w=0 (defaults: 48,48,0,0,48,0).
REQ-031 Reset asserted mid-sequence SHALL fully restart all sequencers on the next edge.

Verification
REQ-032 Reset, en_delta high 12 cycles -> aioht 49, dgates 48; after 96 cycles -> aioht 40, dgates 55; after 672 cycles -> aioht 48.
REQ-033 en_dstate high: after 12 cycles rd 1, wr 0; after 24 cycles rd 2, wr 1; after 96 cycles rd 0, wr 7.
REQ-034 en_dwu high: cycle 1 d 49/w 53; cycle 7 d 55/w 371; cycles 8-9 hold 55/371; cycle 10 d 48/w 1; cycle 530 d 40/w 0.
REQ-035 Toggle en_delta low for 5 cycles mid-window -> outputs frozen, sequence resumes without skipped or repeated addresses.
REQ-036 Assert rst mid-sequence with all enables high -> next edge all outputs at REQ-030 values.

Source files
------------

// File: rtl/bp_addr_gen_bank.sv
// Backprop address generator bank: aioht/dgates, dstate rd/wr and
// d/w matrix address sequencers, each gated by its own enable.
module bp_addr_gen_bank #(
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_CELL     = 8,
  parameter int NUM_INPUT    = 53,
  parameter int TIMESTEP     = 7,
  parameter int DELTA_TIME   = 12,
  parameter int DSTATE_DELAY = 12,
  parameter int DWU_DELAY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_delta,
  input  logic                  en_dstate,
  input  logic                  en_dwu,
  output logic [ADDR_WIDTH-1:0] o_addr_aioht,
  output logic [ADDR_WIDTH-1:0] o_addr_dgates,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_w
);

  localparam int CYC_W  = (DELTA_TIME > 1) ? $clog2(DELTA_TIME) : 1;
  localparam int CELL_W = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
  localparam int T_W    = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam int J_W    = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int G_W    = (DWU_DELAY > 1) ? $clog2(DWU_DELAY) : 1;

  localparam logic [CYC_W-1:0]  CYC_MAX  = CYC_W'(DELTA_TIME - 1);
  localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(NUM_CELL - 1);
  localparam logic [T_W-1:0]    T_MAX    = T_W'(TIMESTEP - 1);
  localparam logic [J_W-1:0]    J_MAX    = J_W'(NUM_INPUT - 1);
  localparam logic [G_W-1:0]    G_MAX    = G_W'(DWU_DELAY - 1);

  localparam logic [ADDR_WIDTH-1:0] RST_ADDR =
    ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);

  // ---------------- aioht / dgates ----------------
  logic [CYC_W-1:0]      a_cyc;
  logic [CELL_W-1:0]     a_cell;
  logic [T_W-1:0]        a_t;
  logic [ADDR_WIDTH-1:0] dgates;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cyc  <= '0;
      a_cell <= '0;
      a_t    <= T_MAX;
      dgates <= RST_ADDR;
    end else if (en_delta) begin
      if (a_cyc == CYC_MAX) begin
        a_cyc  <= '0;
        dgates <= o_addr_aioht;
        if (a_cell == CELL_MAX) begin
          a_cell <= '0;
          a_t    <= (a_t == '0) ? T_MAX : a_t - T_W'(1);
        end else begin
          a_cell <= a_cell + CELL_W'(1);
        end
      end else begin
        a_cyc <= a_cyc + CYC_W'(1);
      end
    end
  end

  assign o_addr_aioht = ADDR_WIDTH'(a_t) * ADDR_WIDTH'(NUM_CELL)
                      + ADDR_WIDTH'(a_cell);
  assign o_addr_dgates = dgates;

  // ---------------- dstate rd / wr ----------------
  logic [CYC_W-1:0]  s_cyc;
  logic [CELL_W-1:0] s_cell;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_cyc  <= '0;
      s_cell <= '0;
    end else if (en_dstate) begin
      if (s_cyc == CYC_MAX) begin
        s_cyc  <= '0;
        s_cell <= (s_cell == CELL_MAX) ? '0 : s_cell + CELL_W'(1);
      end else begin
        s_cyc <= s_cyc + CYC_W'(1);
      end
    end
  end

  assign o_addr_rd = ADDR_WIDTH'(s_cell);

  // Zero-filled delay line gives wr=0 for the first DSTATE_DELAY cycles
  generate
    if (DSTATE_DELAY == 0) begin : g_no_dly
      assign o_addr_wr = o_addr_rd;
    end else begin : g_dly
      logic [ADDR_WIDTH-1:0] sr [DSTATE_DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DSTATE_DELAY; i++)
            sr[i] <= '0;
        end else if (en_dstate) begin
          sr[0] <= o_addr_rd;
          for (int i = 1; i < DSTATE_DELAY; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign o_addr_wr = sr[DSTATE_DELAY-1];
    end
  endgenerate

  // ---------------- d / w matrix FSM ----------------
  typedef enum logic {ACTIVE, GAP} dwu_st_t;

  dwu_st_t           st, st_n;
  logic [CELL_W-1:0] k, k_n;
  logic [J_W-1:0]    j, j_n;
  logic [T_W-1:0]    w_t, w_t_n;
  logic [G_W-1:0]    g, g_n;
  logic              adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= ACTIVE;
      k   <= '0;
      j   <= '0;
      w_t <= T_MAX;
      g   <= '0;
    end else begin
      st  <= st_n;
      k   <= k_n;
      j   <= j_n;
      w_t <= w_t_n;
      g   <= g_n;
    end
  end

  always_comb begin
    st_n  = st;
    k_n   = k;
    j_n   = j;
    w_t_n = w_t;
    g_n   = g;
    adv   = 1'b0;
    if (en_dwu) begin
      unique case (st)
        ACTIVE: begin
          if (k == CELL_MAX) begin
            if (DWU_DELAY == 0) begin
              adv = 1'b1;
            end else begin
              st_n = GAP;
              g_n  = '0;
            end
          end else begin
            k_n = k + CELL_W'(1);
          end
        end
        GAP: begin
          if (g == G_MAX) adv = 1'b1;
          else            g_n = g + G_W'(1);
        end
      endcase
    end
    // Row advance: next input column, stepping back a timestep on wrap
    if (adv) begin
      st_n = ACTIVE;
      k_n  = '0;
      if (j == J_MAX) begin
        j_n   = '0;
        w_t_n = (w_t == '0) ? T_MAX : w_t - T_W'(1);
      end else begin
        j_n = j + J_W'(1);
      end
    end
  end

  always_comb begin
    o_addr_d = ADDR_WIDTH'(w_t) * ADDR_WIDTH'(NUM_CELL)
             + ADDR_WIDTH'(k);
    o_addr_w = ADDR_WIDTH'(k) * ADDR_WIDTH'(NUM_INPUT)
             + ADDR_WIDTH'(j);
  end

endmodule

// File: tb/tb_bp_addr_gen_bank.sv
// Self-checking bench for bp_addr_gen_bank: closed-form model from
// enabled-cycle counts plus literal spot checks.
module tb_bp_addr_gen_bank;

  localparam int AW = 12;
  localparam int NC = 8;
  localparam int NI = 53;
  localparam int TS = 7;
  localparam int DT = 12;
  localparam int DD = 12;
  localparam int WD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_delta = 1'b0;
  logic en_dstate = 1'b0;
  logic en_dwu = 1'b0;
  logic [AW-1:0] aioht, dgates, rd, wr, d, w;

  int checks = 0;
  int errors = 0;
  int n_dl = 0, n_ds = 0, n_dw = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  bp_addr_gen_bank #(
    .ADDR_WIDTH(AW), .NUM_CELL(NC), .NUM_INPUT(NI),
    .TIMESTEP(TS), .DELTA_TIME(DT),
    .DSTATE_DELAY(DD), .DWU_DELAY(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .en_delta(en_delta), .en_dstate(en_dstate), .en_dwu(en_dwu),
    .o_addr_aioht(aioht), .o_addr_dgates(dgates),
    .o_addr_rd(rd), .o_addr_wr(wr),
    .o_addr_d(d), .o_addr_w(w)
  );

  function automatic logic [AW-1:0] m_aioht(int n);
    int win = n / DT;
    int t = (TS - 1) - (win / NC) % TS;
    return AW'(t * NC + win % NC);
  endfunction

  function automatic logic [AW-1:0] m_dgates(int n);
    int win = n / DT;
    if (win == 0) return AW'((TS - 1) * NC);
    return m_aioht((win - 1) * DT);
  endfunction

  function automatic logic [AW-1:0] m_rd(int n);
    return AW'((n / DT) % NC);
  endfunction

  function automatic logic [AW-1:0] m_wr(int n);
    if (n < DD) return '0;
    return m_rd(n - DD);
  endfunction

  function automatic int m_k(int n);
    int p = n % (NC + WD);
    return (p > NC - 1) ? NC - 1 : p;
  endfunction

  function automatic logic [AW-1:0] m_d(int n);
    int r = n / (NC + WD);
    int t = (TS - 1) - (r / NI) % TS;
    return AW'(t * NC + m_k(n));
  endfunction

  function automatic logic [AW-1:0] m_w(int n);
    int r = n / (NC + WD);
    return AW'(m_k(n) * NI + r % NI);
  endfunction

  task automatic chk(string name, logic [AW-1:0] act,
                     logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      started <= 1'b1;
      n_dl <= 0;
      n_ds <= 0;
      n_dw <= 0;
    end else begin
      n_dl <= n_dl + int'(en_delta);
      n_ds <= n_ds + int'(en_dstate);
      n_dw <= n_dw + int'(en_dwu);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model aioht", aioht, m_aioht(n_dl));
      chk("model dgates", dgates, m_dgates(n_dl));
      chk("model rd", rd, m_rd(n_ds));
      chk("model wr", wr, m_wr(n_ds));
      chk("model d", d, m_d(n_dw));
      chk("model w", w, m_w(n_dw));
    end
  end

  task automatic step(bit r, bit a, bit b, bit c);
    rst = r;
    en_delta = a;
    en_dstate = b;
    en_dwu = c;
    @(negedge clk);
  endtask

  task automatic run(int n, bit a, bit b, bit c);
    for (int i = 0; i < n; i++) step(1'b0, a, b, c);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " aioht"}, aioht, 12'd48);
    chk({tag, " dgates"}, dgates, 12'd48);
    chk({tag, " rd"}, rd, 12'd0);
    chk({tag, " wr"}, wr, 12'd0);
    chk({tag, " d"}, d, 12'd48);
    chk({tag, " w"}, w, 12'd0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_reset("reset");

    run(12, 1, 0, 0);
    chk("dl12 aioht", aioht, 12'd49);
    chk("dl12 dgates", dgates, 12'd48);
    run(84, 1, 0, 0);
    chk("dl96 aioht", aioht, 12'd40);
    chk("dl96 dgates", dgates, 12'd55);
    run(576, 1, 0, 0);
    chk("dl672 aioht", aioht, 12'd48);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(12, 0, 1, 0);
    chk("ds12 rd", rd, 12'd1);
    chk("ds12 wr", wr, 12'd0);
    run(12, 0, 1, 0);
    chk("ds24 rd", rd, 12'd2);
    chk("ds24 wr", wr, 12'd1);
    run(72, 0, 1, 0);
    chk("ds96 rd", rd, 12'd0);
    chk("ds96 wr", wr, 12'd7);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 0, 0, 1);
    chk("dw1 d", d, 12'd49);
    chk("dw1 w", w, 12'd53);
    run(6, 0, 0, 1);
    chk("dw7 d", d, 12'd55);
    chk("dw7 w", w, 12'd371);
    run(1, 0, 0, 1);
    chk("dw8 d", d, 12'd55);
    chk("dw8 w", w, 12'd371);
    run(1, 0, 0, 1);
    chk("dw9 d", d, 12'd55);
    chk("dw9 w", w, 12'd371);
    run(1, 0, 0, 1);
    chk("dw10 d", d, 12'd48);
    chk("dw10 w", w, 12'd1);
    run(520, 0, 0, 1);
    chk("dw530 d", d, 12'd40);
    chk("dw530 w", w, 12'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(17, 1, 0, 0);
    chk("pre-pause aioht", aioht, 12'd49);
    run(5, 0, 0, 0);
    chk("pause aioht", aioht, 12'd49);
    chk("pause dgates", dgates, 12'd48);
    run(7, 1, 0, 0);
    chk("resume aioht", aioht, 12'd50);
    chk("resume dgates", dgates, 12'd49);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(3800, 1, 1, 1);

    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end

    run(137, 1, 1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_reset("mid rst");

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
